// File: rtl/line_fill_responder.sv
// Next-level memory model: buffers fill/writeback requests in an in-order FIFO and
// returns a line-aligned completion after a fixed access latency.
module line_fill_responder #(
   parameter int unsigned LINESIZE     = 16,
   parameter int unsigned ADDRESS_SIZE = 16,
   parameter int unsigned LATENCY      = 4,
   parameter int unsigned QDEPTH       = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_rw,
   input  logic [ADDRESS_SIZE-1:0] req_addr,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_rw,
   output logic [ADDRESS_SIZE-1:0] rsp_addr,
   output logic [31:0]             num_fills,
   output logic [31:0]             num_writebacks,
   output logic [31:0]             busy_cycles
);
   localparam int unsigned BS_W  = $clog2(LINESIZE);
   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = ADDRESS_SIZE + 1;
   localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~ADDRESS_SIZE'((1 << BS_W) - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $fatal(1, "line_fill_responder: LATENCY must be in 1..255");
   end
   if (LINESIZE < 8 || LINESIZE > 128 || (LINESIZE & (LINESIZE - 1)) != 0) begin : g_bad_linesize
      $fatal(1, "line_fill_responder: LINESIZE must be a power of 2 in 8..128");
   end
   if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
      $fatal(1, "line_fill_responder: QDEPTH must be a power of 2, at least 2");
   end

   logic [ENT_W-1:0] mem [QDEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_n;
   logic [1:0]       state;
   logic [1:0]       state_n;
   logic [7:0]       cnt;
   logic [7:0]       cnt_n;
   logic             push;
   logic             pop;
   logic             done;

   assign push = req_valid && req_ready;

   // Next-state, FIFO pop and completion decode
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pop     = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               cnt_n   = 8'(LATENCY - 1);
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) state_n = RESP;
            else           cnt_n   = cnt - 8'd1;
         end
         RESP: begin
            if (rsp_ready) begin
               done = 1'b1;
               if (count != '0) begin
                  pop     = 1'b1;
                  cnt_n   = 8'(LATENCY - 1);
                  state_n = WAIT;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      count_n = count + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         count          <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         req_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_rw         <= 1'b0;
         rsp_addr       <= '0;
         num_fills      <= '0;
         num_writebacks <= '0;
         busy_cycles    <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         count     <= count_n;
         // Ready follows the post-edge occupancy, so a full FIFO never bypasses a pop
         req_ready <= (count_n < CNT_W'(QDEPTH));
         rsp_valid <= (state_n == RESP);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr             <= rd_ptr + PTR_W'(1);
            {rsp_rw, rsp_addr} <= mem[rd_ptr];
         end
         if (done) begin
            if (rsp_rw) num_writebacks <= num_writebacks + 32'd1;
            else        num_fills      <= num_fills + 32'd1;
         end
         if (state == WAIT || state == RESP) busy_cycles <= busy_cycles + 32'd1;
      end
   end

   // Request storage; reset only needs to clear the pointers
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {req_rw, req_addr & ALIGN_MASK};
   end
endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: directed scenarios plus random traffic against a
// transaction-level model of service start times, ordering and statistics.
module tb_line_fill_responder;
   localparam int unsigned LINESIZE     = 16;
   localparam int unsigned ADDRESS_SIZE = 16;
   localparam int unsigned LATENCY      = 4;
   localparam int unsigned QDEPTH       = 4;
   localparam logic [15:0] MASK = 16'hFFF0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_rw = 1'b0;
   logic [15:0] req_addr = '0;
   logic        rsp_ready = 1'b0;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_rw;
   logic [15:0] rsp_addr;
   logic [31:0] num_fills;
   logic [31:0] num_writebacks;
   logic [31:0] busy_cycles;

   line_fill_responder #(
      .LINESIZE(LINESIZE), .ADDRESS_SIZE(ADDRESS_SIZE), .LATENCY(LATENCY), .QDEPTH(QDEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw), .rsp_addr(rsp_addr),
      .num_fills(num_fills), .num_writebacks(num_writebacks), .busy_cycles(busy_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [15:0] addr;
      int          acc;
   } req_t;

   // Accepted requests in order; q[0] is the one in (or next for) service
   req_t        q[$];
   int          edge_n = 0;
   int          last_h = 0;
   int          n_acc = 0;
   int          vectors = 0;
   int          errors = 0;
   int unsigned m_fills = 0;
   int unsigned m_wbs = 0;
   int unsigned m_busy = 0;
   int unsigned e_busy = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // Service of the head starts when it is popped: one edge after acceptance,
   // or on the completion edge of its predecessor if that comes later.
   function automatic int head_start();
      return (q[0].acc + 1 > last_h) ? q[0].acc + 1 : last_h;
   endfunction

   task automatic step();
      logic acc;
      logic hs;
      req_t r;
      int   s;
      int   fc;
      int   qs;
      logic exp_v;
      acc    = req_valid && req_ready;
      hs     = rsp_valid && rsp_ready;
      r.rw   = req_rw;
      r.addr = req_addr & MASK;
      @(posedge clk);
      edge_n++;
      r.acc = edge_n;
      @(negedge clk);
      qs = q.size();
      if (acc) begin
         q.push_back(r);
         n_acc++;
      end
      if (hs && qs > 0) begin
         s = head_start();
         m_busy += 32'(edge_n - s);
         if (q[0].rw) m_wbs++;
         else         m_fills++;
         last_h = edge_n;
         void'(q.pop_front());
      end
      fc     = q.size();
      exp_v  = 1'b0;
      e_busy = m_busy;
      if (q.size() > 0) begin
         s = head_start();
         if (edge_n >= s) fc--;
         exp_v = (edge_n >= s + int'(LATENCY));
         if (edge_n > s) e_busy += 32'(edge_n - s);
      end
      check("req_ready", 32'(req_ready), 32'(fc < int'(QDEPTH)));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
         check("rsp_rw", 32'(rsp_rw), 32'(q[0].rw));
         check("rsp_addr", 32'(rsp_addr), 32'(q[0].addr));
      end
      check("num_fills", num_fills, m_fills);
      check("num_writebacks", num_writebacks, m_wbs);
      check("busy_cycles", busy_cycles, e_busy);
   endtask

   task automatic do_reset();
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      @(posedge clk);
      edge_n++;
      #2 reset = 1'b1;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rw", 32'(rsp_rw), 32'd0);
      check("rst_rsp_addr", 32'(rsp_addr), 32'd0);
      check("rst_num_fills", num_fills, 32'd0);
      check("rst_num_writebacks", num_writebacks, 32'd0);
      check("rst_busy_cycles", busy_cycles, 32'd0);
      repeat (2) begin
         @(posedge clk);
         edge_n++;
      end
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      m_fills = 0;
      m_wbs   = 0;
      m_busy  = 0;
      last_h  = 0;
      step();
   endtask

   initial begin
      int          lat;
      int          a0;
      int unsigned f0;
      int unsigned w0;
      int unsigned b0;
      int          hs_edges[$];
      int          h_prev;

      // Reset then idle
      do_reset();
      repeat (20) step();

      // Single fill
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = 16'h1237;
      step();
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         step();
         lat++;
      end
      check("fill_latency", 32'(lat), 32'(LATENCY + 1));
      check("fill_addr", 32'(rsp_addr), 32'h1230);
      check("fill_rw", 32'(rsp_rw), 32'd0);
      step();
      check("fill_count", num_fills, 32'd1);
      check("fill_busy", busy_cycles, 32'd5);
      repeat (3) step();

      // FIFO full with the response side stalled
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      a0 = n_acc;
      for (int i = 0; i < 10; i++) begin
         req_rw   = 1'($urandom_range(0, 1));
         req_addr = 16'($urandom);
         step();
      end
      check("full_accepted", 32'(n_acc - a0), 32'(QDEPTH + 1));
      check("full_ready_low", 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("full_ready_back", 32'(req_ready), 32'd1);
      step();
      check("full_sixth", 32'(n_acc - a0), 32'(QDEPTH + 2));
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (40) step();

      // Back-to-back ordering
      f0 = m_fills;
      w0 = m_wbs;
      req_valid = 1'b1;
      req_rw = 1'b0; req_addr = 16'h0100; step();
      req_rw = 1'b1; req_addr = 16'h0200; step();
      req_rw = 1'b0; req_addr = 16'h0300; step();
      req_valid = 1'b0;
      h_prev = last_h;
      for (int i = 0; i < 40; i++) begin
         step();
         if (last_h != h_prev) begin
            hs_edges.push_back(last_h);
            h_prev = last_h;
         end
      end
      check("b2b_count", 32'(hs_edges.size()), 32'd3);
      if (hs_edges.size() == 3) begin
         check("b2b_gap1", 32'(hs_edges[1] - hs_edges[0]), 32'(LATENCY + 1));
         check("b2b_gap2", 32'(hs_edges[2] - hs_edges[1]), 32'(LATENCY + 1));
      end
      check("b2b_fills", num_fills, f0 + 2);
      check("b2b_wbs", num_writebacks, w0 + 1);

      // Response stall
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_rw    = 1'b1;
      req_addr  = 16'h4567;
      step();
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         step();
         lat++;
      end
      b0 = e_busy;
      w0 = m_wbs;
      for (int i = 0; i < 10; i++) begin
         step();
         check("stall_addr", 32'(rsp_addr), 32'h4560);
         check("stall_rw", 32'(rsp_rw), 32'd1);
      end
      check("stall_busy", busy_cycles, b0 + 10);
      check("stall_wbs", num_writebacks, w0);
      rsp_ready = 1'b1;
      repeat (3) step();

      // Reset mid-operation: one in WAIT, three queued
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_rw   = 1'($urandom_range(0, 1));
         req_addr = 16'($urandom);
         step();
      end
      do_reset();
      rsp_ready = 1'b1;
      repeat (20) step();
      check("mid_rst_fills", num_fills, 32'd0);
      check("mid_rst_wbs", num_writebacks, 32'd0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         req_valid = ($urandom_range(0, 99) < 50);
         req_rw    = 1'($urandom_range(0, 1));
         req_addr  = 16'($urandom);
         rsp_ready = ($urandom_range(0, 99) < 60);
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (40) step();
      check("drain_empty", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
